// File: rtl/elbeth_branch_predict_unit_pkg.sv
// Shared definitions for the elbeth branch unit: branch opcodes, 2-bit
// direction counter encodings and small helpers used by the top and the BTB.
package elbeth_branch_predict_unit_pkg;

   // Branch opcodes. Conditional codes reuse the RISC-V funct3 values, and the
   // two gaps (010, 011) carry the unconditional jumps.
   typedef enum logic [2:0] {
      OP_BEQ  = 3'b000,
      OP_BNE  = 3'b001,
      OP_JAL  = 3'b010,
      OP_JALR = 3'b011,
      OP_BLT  = 3'b100,
      OP_BGE  = 3'b101,
      OP_BLTU = 3'b110,
      OP_BGEU = 3'b111
   } op_e;

   // 2-bit saturating direction counter; bit 1 is the taken prediction.
   typedef enum logic [1:0] {
      CNT_SNT = 2'b00,
      CNT_WNT = 2'b01,
      CNT_WT  = 2'b10,
      CNT_ST  = 2'b11
   } cnt_e;

   // True for every opcode the unit resolves.
   function automatic logic is_branch(input logic [2:0] op);
      logic r;
      r = 1'b0;
      case (op)
         OP_BEQ, OP_BNE, OP_JAL, OP_JALR,
         OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: r = 1'b1;
         default:                          r = 1'b0;
      endcase
      return r;
   endfunction

   // Unconditional jumps are always taken and train straight to strongly taken.
   function automatic logic is_jump(input logic [2:0] op);
      return (op == OP_JAL) || (op == OP_JALR);
   endfunction

   // Saturating counter step toward the resolved direction.
   function automatic cnt_e cnt_next(input cnt_e c, input logic taken);
      cnt_e r;
      r = c;
      if (taken) begin
         if (c != CNT_ST) r = cnt_e'(c + 2'd1);
      end else begin
         if (c != CNT_SNT) r = cnt_e'(c - 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/elbeth_btb.sv
// Direct-mapped branch target buffer: two combinational lookup ports (fetch
// prediction and ID training), one write port, synchronous clear on reset.
// Reads always return the state before the current edge's write (no bypass).
module elbeth_btb
   import elbeth_branch_predict_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   // lookup port A (fetch)
   input  logic [IDX_W-1:0]          a_idx_i,
   input  logic [XLEN-IDX_W-3:0]     a_tag_i,
   output logic                      a_hit_o,
   output logic [XLEN-1:0]           a_target_o,
   output cnt_e                      a_cnt_o,
   // lookup port B (ID training)
   input  logic [IDX_W-1:0]          b_idx_i,
   input  logic [XLEN-IDX_W-3:0]     b_tag_i,
   output logic                      b_hit_o,
   output logic [XLEN-1:0]           b_target_o,
   output cnt_e                      b_cnt_o,
   // write port
   input  logic                      we_i,
   input  logic [IDX_W-1:0]          wr_idx_i,
   input  logic [XLEN-IDX_W-3:0]     wr_tag_i,
   input  logic [XLEN-1:0]           wr_target_i,
   input  cnt_e                      wr_cnt_i
);

   localparam int DEPTH = 1 << IDX_W;
   localparam int TAG_W = XLEN - IDX_W - 2;

   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [XLEN-1:0]  target_q [DEPTH];
   cnt_e             cnt_q    [DEPTH];

   // Lookups: a hit needs a valid entry whose stored tag matches.
   always_comb begin
      a_hit_o    = valid_q[a_idx_i] && (tag_q[a_idx_i] == a_tag_i);
      a_target_o = target_q[a_idx_i];
      a_cnt_o    = cnt_q[a_idx_i];
      b_hit_o    = valid_q[b_idx_i] && (tag_q[b_idx_i] == b_tag_i);
      b_target_o = target_q[b_idx_i];
      b_cnt_o    = cnt_q[b_idx_i];
   end

   // Entry storage: reset invalidates everything and wins over a pending write.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            cnt_q[i]   <= CNT_WNT;
         end
      end else if (we_i) begin
         valid_q[wr_idx_i]  <= 1'b1;
         tag_q[wr_idx_i]    <= wr_tag_i;
         target_q[wr_idx_i] <= wr_target_i;
         cnt_q[wr_idx_i]    <= wr_cnt_i;
      end
   end

endmodule

// File: rtl/elbeth_branch_predict_unit.sv
// Branch unit: BTB-based next-PC prediction for IF, branch resolution for ID,
// single-cycle redirect on mispredict, predictor training and perf counters.
//
// Qualification: an ID instruction is resolved (and may redirect, train and
// count) only in a cycle where id_valid=1, id_stall=0, rst=0 and the opcode is
// a branch code. There is no backpressure; a redirect is a pure pulse and ID
// must be flushed by the pipeline or it resolves again next cycle.
module elbeth_branch_predict_unit
   import elbeth_branch_predict_unit_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BTB_DEPTH = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   output logic            if_pred_taken,
   output logic [XLEN-1:0] if_pred_target,
   input  logic            id_valid,
   input  logic            id_stall,
   input  logic [XLEN-1:0] id_pc,
   input  logic [2:0]      id_operation,
   input  logic [XLEN-1:0] id_offset,
   input  logic [XLEN-1:0] id_data_rs1,
   input  logic [XLEN-1:0] id_data_rs2,
   input  logic            id_pred_taken,
   input  logic [XLEN-1:0] id_pred_target,
   output logic            id_branch_taken,
   output logic [XLEN-1:0] id_pc_branch,
   output logic            id_redirect,
   output logic [XLEN-1:0] id_redirect_pc,
   output logic [XLEN-1:0] perf_branches,
   output logic [XLEN-1:0] perf_mispredicts
);

   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   // PC bits [1:0] never take part in indexing or tagging.
   logic unused_pc_lsbs;
   assign unused_pc_lsbs = ^{if_pc[1:0], id_pc[1:0]};

   logic [IDX_W-1:0] if_idx, id_idx;
   logic [TAG_W-1:0] if_tag, id_tag;
   assign if_idx = if_pc[IDX_W+1:2];
   assign if_tag = if_pc[XLEN-1:IDX_W+2];
   assign id_idx = id_pc[IDX_W+1:2];
   assign id_tag = id_pc[XLEN-1:IDX_W+2];

   logic            if_hit, id_hit;
   logic [XLEN-1:0] if_btb_target, id_btb_target;
   cnt_e            if_cnt, id_cnt;

   logic            upd_we;
   logic [XLEN-1:0] upd_target;
   cnt_e            upd_cnt;

   elbeth_btb #(
      .XLEN  (XLEN),
      .IDX_W (IDX_W)
   ) u_btb (
      .clk_i       (clk),
      .rst_i       (rst),
      .a_idx_i     (if_idx),
      .a_tag_i     (if_tag),
      .a_hit_o     (if_hit),
      .a_target_o  (if_btb_target),
      .a_cnt_o     (if_cnt),
      .b_idx_i     (id_idx),
      .b_tag_i     (id_tag),
      .b_hit_o     (id_hit),
      .b_target_o  (id_btb_target),
      .b_cnt_o     (id_cnt),
      .we_i        (upd_we),
      .wr_idx_i    (id_idx),
      .wr_tag_i    (id_tag),
      .wr_target_i (upd_target),
      .wr_cnt_i    (upd_cnt)
   );

   // Fetch prediction: taken only on a hit with the counter's upper bit set.
   always_comb begin
      if_pred_taken  = !rst && if_hit && if_cnt[1];
      if_pred_target = if_pred_taken ? if_btb_target : '0;
   end

   logic            res;
   logic            taken;
   logic [XLEN-1:0] target;
   logic            mispredict;
   logic [XLEN-1:0] pc_plus_off, rs1_plus_off, pc_plus_4;
   logic            op_eq, op_lt_s, op_lt_u;

   assign pc_plus_off  = id_pc + id_offset;
   assign rs1_plus_off = id_data_rs1 + id_offset;
   assign pc_plus_4    = id_pc + XLEN'(4);
   assign op_eq        = (id_data_rs1 == id_data_rs2);
   assign op_lt_s      = ($signed(id_data_rs1) < $signed(id_data_rs2));
   assign op_lt_u      = (id_data_rs1 < id_data_rs2);

   // Resolution: direction and target from operands, then gate all outputs.
   always_comb begin
      taken           = 1'b0;
      target          = pc_plus_off;
      res             = id_valid && !id_stall && !rst && is_branch(id_operation);
      id_branch_taken = 1'b0;
      id_pc_branch    = '0;
      id_redirect     = 1'b0;
      id_redirect_pc  = '0;
      mispredict      = 1'b0;
      case (id_operation)
         OP_JAL:  taken = 1'b1;
         OP_JALR: begin
            taken  = 1'b1;
            target = {rs1_plus_off[XLEN-1:1], 1'b0};
         end
         OP_BEQ:  taken = op_eq;
         OP_BNE:  taken = !op_eq;
         OP_BLT:  taken = op_lt_s;
         OP_BGE:  taken = !op_lt_s;
         OP_BLTU: taken = op_lt_u;
         OP_BGEU: taken = !op_lt_u;
         default: taken = 1'b0;
      endcase
      if (res) begin
         id_branch_taken = taken;
         id_pc_branch    = target;
         id_redirect_pc  = taken ? target : pc_plus_4;
         mispredict      = (taken != id_pred_taken) ||
                           (taken && (target != id_pred_target));
         id_redirect     = mispredict;
      end
   end

   // Predictor training: update a hit, allocate on a taken miss.
   always_comb begin
      upd_we     = 1'b0;
      upd_cnt    = CNT_WNT;
      upd_target = target;
      if (res) begin
         if (id_hit) begin
            upd_we = 1'b1;
            if (is_jump(id_operation)) begin
               upd_cnt    = CNT_ST;
               upd_target = target;
            end else begin
               upd_cnt    = cnt_next(id_cnt, taken);
               upd_target = taken ? target : id_btb_target;
            end
         end else if (taken) begin
            upd_we     = 1'b1;
            upd_cnt    = is_jump(id_operation) ? CNT_ST : CNT_WT;
            upd_target = target;
         end
      end
   end

   logic [XLEN-1:0] perf_branches_q, perf_branches_d;
   logic [XLEN-1:0] perf_mispredicts_q, perf_mispredicts_d;

   // Wrap-around event counters.
   always_comb begin
      perf_branches_d    = perf_branches_q + XLEN'(res);
      perf_mispredicts_d = perf_mispredicts_q + XLEN'(mispredict);
   end

   // Counter registers; reset clears both.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_branches_q    <= '0;
         perf_mispredicts_q <= '0;
      end else begin
         perf_branches_q    <= perf_branches_d;
         perf_mispredicts_q <= perf_mispredicts_d;
      end
   end

   assign perf_branches    = perf_branches_q;
   assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_elbeth_branch_predict_unit.sv
// Directed bench for elbeth_branch_predict_unit with hand-computed expectations.
module tb_elbeth_branch_predict_unit;
   import elbeth_branch_predict_unit_pkg::*;

   logic        clk;
   logic        rst;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [31:0] if_pred_target;
   logic        id_valid;
   logic        id_stall;
   logic [31:0] id_pc;
   logic [2:0]  id_operation;
   logic [31:0] id_offset;
   logic [31:0] id_data_rs1;
   logic [31:0] id_data_rs2;
   logic        id_pred_taken;
   logic [31:0] id_pred_target;
   logic        id_branch_taken;
   logic [31:0] id_pc_branch;
   logic        id_redirect;
   logic [31:0] id_redirect_pc;
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;

   int checks = 0;
   int errors = 0;

   elbeth_branch_predict_unit #(
      .XLEN      (32),
      .BTB_DEPTH (64)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .if_pred_target   (if_pred_target),
      .id_valid         (id_valid),
      .id_stall         (id_stall),
      .id_pc            (id_pc),
      .id_operation     (id_operation),
      .id_offset        (id_offset),
      .id_data_rs1      (id_data_rs1),
      .id_data_rs2      (id_data_rs2),
      .id_pred_taken    (id_pred_taken),
      .id_pred_target   (id_pred_target),
      .id_branch_taken  (id_branch_taken),
      .id_pc_branch     (id_pc_branch),
      .id_redirect      (id_redirect),
      .id_redirect_pc   (id_redirect_pc),
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #100000;
      $display("FAIL watchdog obs=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
      end
   endtask

   task automatic id_idle();
      id_valid       = 1'b0;
      id_stall       = 1'b0;
      id_pc          = '0;
      id_operation   = OP_BEQ;
      id_offset      = '0;
      id_data_rs1    = '0;
      id_data_rs2    = '0;
      id_pred_taken  = 1'b0;
      id_pred_target = '0;
   endtask

   task automatic id_drive(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] off,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           input logic pt, input logic [31:0] ptgt);
      id_valid       = 1'b1;
      id_stall       = 1'b0;
      id_operation   = op;
      id_pc          = pc;
      id_offset      = off;
      id_data_rs1    = rs1;
      id_data_rs2    = rs2;
      id_pred_taken  = pt;
      id_pred_target = ptgt;
   endtask

   // look up the BTB at pc in the current cycle
   task automatic check_pred(input string tag, input logic [31:0] pc,
                             input logic exp_t, input logic [31:0] exp_tgt);
      if_pc = pc;
      #1;
      check_eq({tag, "_taken"}, {31'd0, if_pred_taken}, {31'd0, exp_t});
      check_eq({tag, "_target"}, if_pred_target, exp_tgt);
   endtask

   task automatic check_res(input string tag, input logic exp_t, input logic [31:0] exp_pcb,
                            input logic exp_rd, input logic [31:0] exp_rpc);
      #1;
      check_eq({tag, "_taken"}, {31'd0, id_branch_taken}, {31'd0, exp_t});
      check_eq({tag, "_pcb"}, id_pc_branch, exp_pcb);
      check_eq({tag, "_redir"}, {31'd0, id_redirect}, {31'd0, exp_rd});
      check_eq({tag, "_rpc"}, id_redirect_pc, exp_rpc);
   endtask

   task automatic check_perf(input string tag, input logic [31:0] exp_b, input logic [31:0] exp_m);
      check_eq({tag, "_branches"}, perf_branches, exp_b);
      check_eq({tag, "_mispred"}, perf_mispredicts, exp_m);
   endtask

   initial begin
      rst   = 1'b1;
      if_pc = 32'h100;
      id_idle();

      // reset: a would-be mispredict while rst is high has no effect
      @(negedge clk);
      @(negedge clk);
      id_drive(OP_BEQ, 32'h100, 32'h40, 5, 5, 1'b0, 32'h0);
      check_res("rst_res", 1'b0, 32'h0, 1'b0, 32'h0);
      check_pred("rst_pred", 32'h100, 1'b0, 32'h0);
      check_perf("rst", 0, 0);

      @(negedge clk);
      rst = 1'b0;
      id_idle();
      #1;
      check_pred("post_rst", 32'h100, 1'b0, 32'h0);

      // first BEQ: miss, taken -> redirect and allocate WT; IF still sees old entry
      @(negedge clk);
      id_drive(OP_BEQ, 32'h100, 32'h40, 5, 5, 1'b0, 32'h0);
      check_res("beq0", 1'b1, 32'h140, 1'b1, 32'h140);
      check_pred("beq0_rbw", 32'h100, 1'b0, 32'h0);
      @(negedge clk);
      id_idle();
      check_pred("beq0_after", 32'h100, 1'b1, 32'h140);
      check_perf("beq0", 1, 1);

      // three correctly predicted taken resolutions: 10 -> 11 -> 11 -> 11
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         id_drive(OP_BEQ, 32'h100, 32'h40, 5, 5, 1'b1, 32'h140);
         check_res("beq_t", 1'b1, 32'h140, 1'b0, 32'h140);
         @(negedge clk);
         id_idle();
         check_pred("beq_t_after", 32'h100, 1'b1, 32'h140);
      end

      // not taken: 11 -> 10 (still predicts taken), then 10 -> 01
      @(negedge clk);
      id_drive(OP_BEQ, 32'h100, 32'h40, 5, 6, 1'b1, 32'h140);
      check_res("beq_nt1", 1'b0, 32'h140, 1'b1, 32'h104);
      @(negedge clk);
      id_idle();
      check_pred("beq_nt1_after", 32'h100, 1'b1, 32'h140);
      @(negedge clk);
      id_drive(OP_BEQ, 32'h100, 32'h40, 5, 6, 1'b1, 32'h140);
      check_res("beq_nt2", 1'b0, 32'h140, 1'b1, 32'h104);
      @(negedge clk);
      id_idle();
      check_pred("beq_nt2_after", 32'h100, 1'b0, 32'h0);
      check_perf("beq_seq", 6, 3);

      // JALR clears only bit 0; allocation with ST survives one not-taken step
      @(negedge clk);
      id_drive(OP_JALR, 32'h204, 32'h0, 32'h2003, 32'h0, 1'b0, 32'h0);
      check_res("jalr", 1'b1, 32'h2002, 1'b1, 32'h2002);
      @(negedge clk);
      id_idle();
      check_pred("jalr_after", 32'h204, 1'b1, 32'h2002);
      @(negedge clk);
      id_drive(OP_BEQ, 32'h204, 32'h40, 1, 2, 1'b1, 32'h2002);
      check_res("jalr_nt", 1'b0, 32'h244, 1'b1, 32'h208);
      @(negedge clk);
      id_idle();
      check_pred("jalr_cnt11", 32'h204, 1'b1, 32'h2002);
      check_perf("jalr", 8, 5);

      // aliasing: retrain 0x100 to taken, then 0x100 + 4*64 misses on tag
      @(negedge clk);
      id_drive(OP_BEQ, 32'h100, 32'h40, 7, 7, 1'b0, 32'h0);
      check_res("alias_train", 1'b1, 32'h140, 1'b1, 32'h140);
      @(negedge clk);
      id_idle();
      check_pred("alias_hit", 32'h100, 1'b1, 32'h140);
      check_pred("alias_miss", 32'h200, 1'b0, 32'h0);
      check_perf("alias", 9, 6);

      // stalled mispredicting BLTU: nothing happens; unstalled: redirect and count
      @(negedge clk);
      id_drive(OP_BLTU, 32'h308, 32'h10, 32'h1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      id_stall = 1'b1;
      check_res("bltu_stall", 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      check_pred("bltu_stall_after", 32'h308, 1'b0, 32'h0);
      check_perf("bltu_stall", 9, 6);
      id_stall = 1'b0;
      check_res("bltu_go", 1'b1, 32'h318, 1'b1, 32'h318);
      @(negedge clk);
      id_idle();
      check_pred("bltu_after", 32'h308, 1'b1, 32'h318);
      check_perf("bltu", 10, 7);

      // signed compare: -1 < 1
      @(negedge clk);
      id_drive(OP_BLT, 32'h40C, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h42C);
      check_res("blt", 1'b1, 32'h42C, 1'b0, 32'h42C);
      @(negedge clk);
      id_drive(OP_BGE, 32'h40C, 32'h20, 32'hFFFF_FFFF, 32'h1, 1'b1, 32'h42C);
      check_res("bge", 1'b0, 32'h42C, 1'b1, 32'h410);
      // JAL with negative offset, correct then wrong target prediction
      @(negedge clk);
      id_drive(OP_JAL, 32'h504, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1, 32'h4FC);
      check_res("jal_ok", 1'b1, 32'h4FC, 1'b0, 32'h4FC);
      @(negedge clk);
      id_drive(OP_JAL, 32'h504, 32'hFFFF_FFF8, 32'h0, 32'h0, 1'b1, 32'h500);
      check_res("jal_bad_tgt", 1'b1, 32'h4FC, 1'b1, 32'h4FC);
      // unsigned: 1 >= 0xFFFFFFFF is false
      @(negedge clk);
      id_drive(OP_BGEU, 32'h600, 32'h8, 32'h1, 32'hFFFF_FFFF, 1'b0, 32'h0);
      check_res("bgeu", 1'b0, 32'h608, 1'b0, 32'h604);
      @(negedge clk);
      id_idle();
      check_pred("jal_after", 32'h504, 1'b1, 32'h4FC);
      check_pred("bge_after", 32'h40C, 1'b0, 32'h0);
      check_perf("mix", 15, 9);

      // mispredict counter wraps from all-ones to zero
      @(negedge clk);
      force dut.perf_mispredicts_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.perf_mispredicts_q;
      #1;
      check_perf("preload", 15, 32'hFFFF_FFFF);
      @(negedge clk);
      id_drive(OP_BEQ, 32'h700, 32'h40, 3, 3, 1'b0, 32'h0);
      check_res("wrap_br", 1'b1, 32'h740, 1'b1, 32'h740);
      @(negedge clk);
      id_idle();
      #1;
      check_perf("wrap", 16, 0);

      // reset mid-stream overrides a pending update and clears everything
      @(negedge clk);
      rst = 1'b1;
      id_drive(OP_BNE, 32'h40C, 32'h20, 1, 2, 1'b0, 32'h0);
      check_res("midrst_res", 1'b0, 32'h0, 1'b0, 32'h0);
      check_pred("midrst_pred", 32'h504, 1'b0, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      id_idle();
      check_pred("midrst_504", 32'h504, 1'b0, 32'h0);
      check_pred("midrst_308", 32'h308, 1'b0, 32'h0);
      check_pred("midrst_40c", 32'h40C, 1'b0, 32'h0);
      check_perf("midrst", 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
